// File: rtl/transpose_store_pkg.sv
// Shared configuration and types for the transpose store slice.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
package transpose_store_pkg;

   // Tile geometry and memory-port configuration for the whole slice
   localparam int DATA_WIDTH = 64;
   localparam int NUM_MG     = 8;
   localparam int NUM_PE     = 8;
   localparam int ADDR_WIDTH = 64;
   localparam int ROW_STRIDE = 64;
   localparam int DEPTH      = 2;

   // Widths are kept at least 1 bit so degenerate configurations still elaborate
   localparam int ROW_IDX_W = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
   localparam int OCC_W     = $clog2(DEPTH + 1);
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One memory beat: element j sits at bits [j*DATA_WIDTH +: DATA_WIDTH]
   typedef logic [NUM_PE*DATA_WIDTH-1:0] row_t;
   typedef row_t [NUM_MG-1:0]            tile_t;

   typedef enum logic {IDLE, SEND} state_t;

   // Circular increment over DEPTH slots (DEPTH need not be a power of two)
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/transpose_tile_buf.sv
// Whole-tile FIFO: stores DEPTH tiles plus base addresses, exposes the head.
// Latency: a pushed tile becomes the head on the edge after the push when empty.
// Backpressure: none; caller must not push when full unless popping the same edge.
module transpose_tile_buf
   import transpose_store_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  tile_t                 i_tile,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_pop,
   output tile_t                 o_head_tile,
   output logic [ADDR_WIDTH-1:0] o_head_addr,
   output logic [OCC_W-1:0]      o_occ,
   output logic                  o_full
);

   tile_t                 r_tile [DEPTH];
   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [OCC_W-1:0]      r_occ;

   // Payload storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_tile[r_tail] <= i_tile;
         r_addr[r_tail] <= i_addr;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (i_push) r_tail <= ptr_inc(r_tail);
         if (i_pop)  r_head <= ptr_inc(r_head);
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_head_tile = r_tile[r_head];
   assign o_head_addr = r_addr[r_head];
   assign o_occ       = r_occ;
   assign o_full      = (r_occ == OCC_W'(DEPTH));

endmodule

// File: rtl/transpose_store_unit.sv
// Buffers transposed tiles and streams them row-by-row to a memory write port.
// Latency: row 0 of a tile captured into an empty buffer is valid the next cycle.
// Backpressure: mem_wr_ready stalls rows in place; upstream cannot stall, full buffer drops tiles.
module transpose_store_unit
   import transpose_store_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_val,
   input  tile_t                 in_elements,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   output logic                  mem_wr_val,
   input  logic                  mem_wr_ready,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output row_t                  mem_wr_data,
   output logic                  mem_wr_last,
   output logic                  busy,
   output logic                  overflow,
   output logic [31:0]           tiles_done
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ROW_IDX_W-1:0]  r_row;
   logic                  r_overflow;
   logic [31:0]           r_tiles_done;

   logic                  w_val;
   logic                  w_xfer;
   logic                  w_row_last;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;
   logic [OCC_W-1:0]      w_occ;
   tile_t                 w_head_tile;
   logic [ADDR_WIDTH-1:0] w_head_addr;

   assign w_row_last = (r_row == ROW_IDX_W'(NUM_MG - 1));
   assign w_xfer     = w_val && mem_wr_ready;
   assign w_pop      = w_xfer && w_row_last;
   // A full buffer still accepts when its head tile retires on the same edge
   assign w_push     = in_val && (!w_full || w_pop);

   transpose_tile_buf u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_tile      (in_elements),
      .i_addr      (in_addr),
      .i_pop       (w_pop),
      .o_head_tile (w_head_tile),
      .o_head_addr (w_head_addr),
      .o_occ       (w_occ),
      .o_full      (w_full)
   );

   // State register: SEND exactly while the buffer holds at least one tile
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and beat valid; valid depends only on registered state
   always_comb begin
      w_state_nxt = r_state;
      w_val       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_push) w_state_nxt = SEND;
         end
         SEND: begin
            w_val = 1'b1;
            if (w_pop && !w_push && (w_occ == OCC_W'(1))) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Row counter advances per accepted beat and rewinds when a tile retires
   always_ff @(posedge clk) begin
      if (rst)         r_row <= '0;
      else if (w_xfer) r_row <= w_row_last ? '0 : r_row + ROW_IDX_W'(1);
   end

   // Sticky drop flag and completed-tile counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_tiles_done <= '0;
      end else begin
         if (in_val && !w_push) r_overflow <= 1'b1;
         if (w_pop)             r_tiles_done <= r_tiles_done + 32'd1;
      end
   end

   // Beat fields are zeroed when idle so stale buffer contents never leak out
   assign mem_wr_val  = w_val;
   assign mem_wr_addr = w_val ? (w_head_addr + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(ROW_STRIDE)) : '0;
   assign mem_wr_data = w_val ? w_head_tile[r_row] : '0;
   assign mem_wr_last = w_val && w_row_last;
   assign busy        = w_val;
   assign overflow    = r_overflow;
   assign tiles_done  = r_tiles_done;

endmodule

// File: tb/tb_transpose_store_unit.sv
// Scoreboard bench for transpose_store_unit: directed tiles, queued expected beats.
// Latency: checks row 0 appears the cycle after capture and no-bubble tile chaining.
// Backpressure: exercises ready toggling, full-buffer drop and full-with-pop accept.
module tb_transpose_store_unit;
   import transpose_store_pkg::*;

   localparam int CW = $bits(row_t);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      row_t                  data;
      logic                  last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_val;
   tile_t                 in_elements;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic                  mem_wr_val;
   logic                  mem_wr_ready;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   row_t                  mem_wr_data;
   logic                  mem_wr_last;
   logic                  busy;
   logic                  overflow;
   logic [31:0]           tiles_done;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    beats = 0;
   int    first_cyc = -1;
   int    last_cyc  = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   transpose_store_unit dut (
      .clk          (clk),
      .rst          (rst),
      .in_val       (in_val),
      .in_elements  (in_elements),
      .in_addr      (in_addr),
      .mem_wr_val   (mem_wr_val),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_last  (mem_wr_last),
      .busy         (busy),
      .overflow     (overflow),
      .tiles_done   (tiles_done)
   );

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // element[r][j] = seed + 16*r + j
   function automatic tile_t mk_tile(input logic [63:0] seed);
      tile_t t;
      for (int r = 0; r < NUM_MG; r++)
         for (int j = 0; j < NUM_PE; j++)
            t[r][j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(seed + 64'(16*r + j));
      return t;
   endfunction

   task automatic send_tile(input logic [ADDR_WIDTH-1:0] base, input logic [63:0] seed, input bit accept);
      tile_t t;
      beat_t b;
      t = mk_tile(seed);
      in_val      = 1'b1;
      in_elements = t;
      in_addr     = base;
      if (accept) begin
         for (int r = 0; r < NUM_MG; r++) begin
            b.addr = base + ADDR_WIDTH'(r * ROW_STRIDE);
            b.data = t[r];
            b.last = (r == NUM_MG - 1);
            exp_q.push_back(b);
         end
      end
      @(posedge clk); #1;
      in_val = 1'b0;
   endtask

   // Wait for every expected beat; optional 1,0,0,1 ready pattern
   task automatic drain(input int limit, input bit toggle);
      bit pat [4];
      int n;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         if (toggle) mem_wr_ready = pat[n % 4];
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Monitor: scoreboard pop on each handshake, plus stall-stability checks
   logic [ADDR_WIDTH-1:0] h_addr;
   row_t                  h_data;
   logic                  h_last;
   bit                    h_stall = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         h_stall = 1'b0;
      end else begin
         if (h_stall) begin
            chk("stall_val_held", CW'(mem_wr_val), CW'(1));
            chk("stall_addr", CW'(mem_wr_addr), CW'(h_addr));
            chk("stall_data", mem_wr_data, h_data);
            chk("stall_last", CW'(mem_wr_last), CW'(h_last));
         end
         if (mem_wr_val && mem_wr_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: addr %0h with no beat expected", mem_wr_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_addr", CW'(mem_wr_addr), CW'(e.addr));
               chk("beat_data", mem_wr_data, e.data);
               chk("beat_last", CW'(mem_wr_last), CW'(e.last));
            end
            beats++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         h_stall = mem_wr_val && !mem_wr_ready;
         h_addr  = mem_wr_addr;
         h_data  = mem_wr_data;
         h_last  = mem_wr_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      in_val       = 1'b0;
      in_elements  = '0;
      in_addr      = '0;
      mem_wr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_val", CW'(mem_wr_val), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_overflow", CW'(overflow), CW'(0));
      chk("rst_tiles_done", CW'(tiles_done), CW'(0));
      chk("rst_addr", CW'(mem_wr_addr), CW'(0));
      chk("rst_last", CW'(mem_wr_last), CW'(0));

      // Single tile, ready held high
      @(posedge clk); #1;
      mem_wr_ready = 1'b1;
      beats = 0; first_cyc = -1;
      send_tile(64'h1000, 64'h0, 1'b1);
      @(negedge clk);
      chk("t1_first_val", CW'(mem_wr_val), CW'(1));
      chk("t1_first_addr", CW'(mem_wr_addr), CW'(64'h1000));
      drain(50, 1'b0);
      @(negedge clk);
      chk("t1_beats", CW'(beats), CW'(8));
      chk("t1_consecutive", CW'(last_cyc - first_cyc), CW'(7));
      chk("t1_tiles_done", CW'(tiles_done), CW'(1));
      chk("t1_busy_after", CW'(busy), CW'(0));

      // Same tile shape under toggling backpressure
      @(posedge clk); #1;
      mem_wr_ready = 1'b0;
      beats = 0;
      send_tile(64'h1000, 64'h0, 1'b1);
      drain(200, 1'b1);
      @(negedge clk);
      chk("t2_beats", CW'(beats), CW'(8));
      chk("t2_tiles_done", CW'(tiles_done), CW'(2));
      chk("t2_busy_after", CW'(busy), CW'(0));

      // Back-to-back tiles, no bubble between them
      @(posedge clk); #1;
      mem_wr_ready = 1'b1;
      beats = 0; first_cyc = -1;
      send_tile(64'h0, 64'h200, 1'b1);
      send_tile(64'h2000, 64'h300, 1'b1);
      drain(100, 1'b0);
      @(negedge clk);
      chk("t3_beats", CW'(beats), CW'(16));
      chk("t3_no_bubble", CW'(last_cyc - first_cyc), CW'(15));
      chk("t3_tiles_done", CW'(tiles_done), CW'(4));
      chk("t3_overflow", CW'(overflow), CW'(0));

      // Overflow: third tile dropped while stalled
      @(posedge clk); #1;
      mem_wr_ready = 1'b0;
      send_tile(64'h4000, 64'h400, 1'b1);
      send_tile(64'h5000, 64'h500, 1'b1);
      send_tile(64'h6000, 64'h600, 1'b0);
      @(negedge clk);
      chk("t4_overflow", CW'(overflow), CW'(1));
      chk("t4_busy", CW'(busy), CW'(1));
      @(posedge clk); #1;
      mem_wr_ready = 1'b1;
      beats = 0;
      drain(100, 1'b0);
      @(negedge clk);
      chk("t4_beats", CW'(beats), CW'(16));
      chk("t4_tiles_done", CW'(tiles_done), CW'(6));
      chk("t4_overflow_sticky", CW'(overflow), CW'(1));

      // Full buffer with a tile arriving on the head's final-row edge
      @(posedge clk); #1;
      do_reset();
      mem_wr_ready = 1'b0;
      beats = 0;
      send_tile(64'h7000, 64'h700, 1'b1);
      send_tile(64'h8000, 64'h800, 1'b1);
      mem_wr_ready = 1'b1;
      repeat (7) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t5_last_aligned", CW'(mem_wr_last), CW'(1));
      send_tile(64'h9000, 64'h900, 1'b1);
      drain(100, 1'b0);
      @(negedge clk);
      chk("t5_overflow", CW'(overflow), CW'(0));
      chk("t5_beats", CW'(beats), CW'(24));
      chk("t5_tiles_done", CW'(tiles_done), CW'(3));

      // Reset mid-tile, then a tile whose row addresses wrap
      @(posedge clk); #1;
      mem_wr_ready = 1'b0;
      beats = 0;
      send_tile(64'hA000, 64'hA00, 1'b1);
      mem_wr_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      mem_wr_ready = 1'b0;
      chk("t6_beats_before_rst", CW'(beats), CW'(4));
      do_reset();
      @(negedge clk);
      chk("t6_rst_val", CW'(mem_wr_val), CW'(0));
      chk("t6_rst_busy", CW'(busy), CW'(0));
      chk("t6_rst_tiles_done", CW'(tiles_done), CW'(0));
      @(posedge clk); #1;
      mem_wr_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t6_no_beats_after_rst", CW'(beats), CW'(4));
      send_tile(64'hFFFF_FFFF_FFFF_FFC0, 64'hB00, 1'b1);
      @(negedge clk);
      chk("t6_wrap_row0", CW'(mem_wr_addr), CW'(64'hFFFF_FFFF_FFFF_FFC0));
      @(negedge clk);
      chk("t6_wrap_row1", CW'(mem_wr_addr), CW'(64'h0));
      drain(50, 1'b0);
      @(negedge clk);
      chk("t6_tiles_done", CW'(tiles_done), CW'(1));
      chk("t6_busy_after", CW'(busy), CW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/transpose_store_unit.md
Name: transpose_store_unit

Overview:
- Downstream consumer of the matrix transpose stage.
- Captures each transposed NUM_MG x NUM_PE tile (output_elements / out_val / store_addr) into a small tile FIFO.
- Serialises each tile row-by-row onto a valid/ready memory write port, generating per-row addresses.
- The transpose stage has no backpressure, so this block absorbs bursts and flags overflow when a tile arrives with the FIFO full.

Parameters:
- DATA_WIDTH, 64: bits per element.
- NUM_MG, 8: rows per tile; one memory beat per row.
- NUM_PE, 8: elements per row.
- ADDR_WIDTH, 64: address width.
- ROW_STRIDE, 64: byte offset between consecutive row addresses.
- DEPTH, 2: tile FIFO capacity in whole tiles; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_val  in  1  tile valid (from transpose out_val)
- in_elements  in  DATA_WIDTH x [NUM_MG][NUM_PE]  tile (from transpose output_elements)
- in_addr  in  ADDR_WIDTH  tile base address (from transpose store_addr), sampled with in_val
- mem_wr_val  out  1  write beat valid
- mem_wr_ready  in  1  memory accepts the beat
- mem_wr_addr  out  ADDR_WIDTH  row address
- mem_wr_data  out  NUM_PE*DATA_WIDTH  row data; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- mem_wr_last  out  1  beat is the last row of its tile
- busy  out  1  FIFO non-empty
- overflow  out  1  sticky: a tile was dropped
- tiles_done  out  32  count of fully written tiles; wraps modulo 2^32

Behaviour:
- Reset: rst=1 at a clock edge empties the FIFO and clears row counter, pointers, overflow and tiles_done. All outputs read 0 in the following cycle. Reset mid-tile discards partial tiles; no further beats are emitted.
- Capture: on an edge with in_val=1 and occupancy<DEPTH, the tile and in_addr are written at the tail and occupancy increments.
- Overflow: on an edge with in_val=1 and occupancy==DEPTH, the tile is dropped and overflow sets; it stays set until rst.
- Full-FIFO exception: if the final beat of the head tile handshakes on the same edge, the slot frees that edge and the incoming tile is accepted, not dropped.
- Latency: a tile captured at edge t into an empty FIFO presents row 0 (mem_wr_val=1) in the cycle after t. There is no combinational in_val-to-mem_wr_val path.
- Per-row outputs: while busy, the head tile drives mem_wr_val=1 and row r (0..NUM_MG-1):
  - mem_wr_data = in_elements[r][0..NUM_PE-1]
  - mem_wr_addr = base + r*ROW_STRIDE, truncated to ADDR_WIDTH (wrap-around permitted)
  - mem_wr_last = (r == NUM_MG-1)
- Handshake: a beat transfers on an edge with mem_wr_val && mem_wr_ready, then r increments. Addr, data and last must stay stable while val=1 and ready=0. mem_wr_val never drops without a transfer except on rst.
- Tile completion: the last-row transfer pops the head, resets r to 0 and increments tiles_done. If another tile is queued, its row 0 is presented in the next cycle with no bubble. Otherwise mem_wr_val=0.
- State: a two-state FSM, IDLE (occupancy 0) and SEND (occupancy>0).
  - IDLE -> SEND on capture.
  - SEND -> IDLE on a final-row transfer with no capture and occupancy==1.
- Simultaneous capture and pop: occupancy is unchanged.
- mem_wr_ready is ignored when mem_wr_val=0.

Decomposition:
- Package transpose_store_pkg:
  - row_t typedef (logic [NUM_PE*DATA_WIDTH-1:0])
  - tile_t typedef (row_t [NUM_MG])
  - state enum {IDLE, SEND}
  - localparams ROW_IDX_W = $clog2(NUM_MG) and OCC_W = $clog2(DEPTH+1)
- One sub-module, transpose_tile_buf: DEPTH-entry tile and address storage with head/tail pointers, occupancy, push/pop and a full flag. It exposes the head tile and its address.
- The top level holds the FSM, row counter, address generation, overflow flag and tiles_done.

Test Plan:
- Single tile, all parameters default: tile with element[r][j]=16*r+j, in_addr=0x1000, ready held 1. Require 8 beats on consecutive cycles starting the cycle after in_val, addresses 0x1000, 0x1040 … 0x11C0, and beat 7 data element 0 = 0x70. mem_wr_last only on beat 7; tiles_done=1; busy drops after beat 7.
- Backpressure: same tile with ready toggled 1,0,0,1,… Require addr, data and last unchanged through every stall cycle, exactly 8 transfers, and no duplicated or skipped row.
- Back-to-back tiles: tiles A (addr 0x0) and B (addr 0x2000) on consecutive cycles, ready=1. Require 16 consecutive beats; B row 0 at 0x2000 directly follows A row 7 with no idle cycle; tiles_done=2; overflow=0.
- Overflow: ready=0 and 3 tiles sent with DEPTH=2. The third is dropped and overflow=1. After ready=1, exactly 16 beats (tiles 1 and 2) emerge.
- Full plus simultaneous pop: FIFO full, with a new in_val on the same edge as the head's final-row transfer. Require the new tile accepted, overflow stays 0, and all 3 tiles written.
- Reset mid-tile and address wrap: assert rst after beat 3. The next cycle must show mem_wr_val=0, busy=0 and tiles_done=0. Then send a tile at in_addr=0xFFFF_FFFF_FFFF_FFC0; row 1 must be at 0x0.
